// File: rtl/snd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snd_pkg
// Description : Shared types and constants for the sound-out sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package snd_pkg;

    localparam int SAMPLE_W = 32;
    localparam logic [SAMPLE_W-1:0] SILENCE = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } snd_state_t;

endpackage
`default_nettype wire

// File: rtl/snd_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : snd_sample_fifo
// Description : Synchronous sample FIFO with async reset and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module snd_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    // Head is read combinationally so a pop returns the oldest entry even
    // when a push lands in the same cycle.
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/audio_out_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_sequencer
// Description : Sound-out sequencer: start/stop FSM, burst DMA requests,
//               sample buffering and tick-paced delivery to the I2S sender.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_out_sequencer
    import snd_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int SAMPLES_PER_REQ = 4,
    parameter int PRIME_LEVEL     = 4,
    parameter int UNDERRUN_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cmd_22k,
    output logic                  dma_req,
    input  logic                  smp_valid,
    input  logic [SAMPLE_W-1:0]   smp_data,
    output logic                  smp_ready,
    input  logic                  snd_req_tick,
    input  logic                  snd_req_mode,
    output logic                  snd_valid,
    output logic [SAMPLE_W-1:0]   snd_data,
    output logic                  snd_start,
    output logic                  snd_end,
    output logic                  snd_22k,
    output logic                  active,
    output logic [UNDERRUN_W-1:0] underrun_cnt,
    input  logic                  underrun_clr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(SAMPLES_PER_REQ + 1);
    localparam logic [CW-1:0] PRIME_CNT   = CW'(PRIME_LEVEL);
    localparam logic [CW-1:0] REQ_MAX_CNT = CW'(FIFO_DEPTH - SAMPLES_PER_REQ);
    localparam logic [OW-1:0] REQ_SAMPLES = OW'(SAMPLES_PER_REQ);

    snd_state_t          state;
    snd_state_t          state_nxt;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [OW-1:0]       outstanding;
    logic                tick_act;
    logic                running;
    logic                fifo_pop;
    logic                fifo_push;
    logic                underrun;
    logic                end_now;
    logic                accept;
    logic                req_ok;

    assign tick_act  = snd_req_tick && snd_req_mode;
    assign running   = (state == ST_RUN) || (state == ST_DRAIN);
    assign fifo_pop  = tick_act && running && !fifo_empty;
    assign underrun  = tick_act && (state == ST_RUN) && fifo_empty;
    assign end_now   = tick_act && (state == ST_DRAIN) && fifo_empty;
    assign smp_ready = (outstanding != '0) && !fifo_full;
    assign accept    = smp_valid && smp_ready;
    // A sample arriving on the very tick that ends playback is dropped.
    assign fifo_push = accept && !end_now;
    assign req_ok    = (outstanding == '0) && (fifo_count <= REQ_MAX_CNT);

    snd_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (smp_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        snd_start = 1'b0;
        dma_req   = 1'b0;
        active    = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (cmd_start && !cmd_stop) state_nxt = ST_START;
            end
            ST_START: begin
                snd_start = 1'b1;
                state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                dma_req = req_ok;
                if (cmd_stop)                       state_nxt = ST_DRAIN;
                else if (fifo_count >= PRIME_CNT)   state_nxt = ST_RUN;
            end
            ST_RUN: begin
                dma_req = req_ok;
                if (cmd_stop) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (end_now) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snd_22k     <= 1'b0;
            outstanding <= '0;
            snd_valid   <= 1'b0;
            snd_end     <= 1'b0;
            snd_data    <= SILENCE;
        end else begin
            if ((state == ST_IDLE) && cmd_start && !cmd_stop) snd_22k <= cmd_22k;

            if (end_now)      outstanding <= '0;
            else if (dma_req) outstanding <= REQ_SAMPLES;
            else if (accept)  outstanding <= outstanding - OW'(1);

            snd_valid <= fifo_pop || underrun;
            snd_end   <= end_now;
            if (fifo_pop)      snd_data <= fifo_rdata;
            else if (underrun) snd_data <= SILENCE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun_cnt <= '0;
        else if (underrun_clr)
            underrun_cnt <= '0;
        else if (underrun && (underrun_cnt != '1))
            underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
    end

endmodule
`default_nettype wire
